iob_eth_mii_rx_driver: RTL and testbench

PHY-side MII receive-path driver: reads a frame from a byte buffer and serialises it onto rx_dv/rx_data exactly as a PHY would. It emits preamble, SFD, payload and a computed CRC-32 FCS, then an inter-frame gap. It sits opposite the Ethernet MAC receiver in loopback/test configurations and in frame-injection benches, sharing the MII receive clock.

---
 rtl/iob_eth_mii_rx_driver.sv | 232 +++++++++++++++++++++++
 tb/tb_iob_eth_mii_rx_driver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_mii_rx_driver.sv
// PHY-side MII receive driver: serialises preamble, SFD, a payload fetched
// from a byte buffer and its CRC-32 FCS onto rx_dv/rx_data, low nibble first,
// then holds the line idle for the inter-frame gap.
module iob_eth_mii_rx_driver #(
  parameter int BUF_ADDR_W   = 11,
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_BYTES    = 12
) (
  input  logic                  rx_clk_i,
  input  logic                  arst_i,
  input  logic                  send_i,
  input  logic [BUF_ADDR_W-1:0] frame_len_i,
  input  logic                  crc_corrupt_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  buf_rd_o,
  output logic [BUF_ADDR_W-1:0] buf_addr_o,
  input  logic [7:0]            buf_data_i,
  output logic                  rx_dv_o,
  output logic [3:0]            rx_data_o
);

  // One counter serves preamble bytes, payload bytes, FCS nibbles and IFG
  // cycles; it is one bit wider than the address so len+1 never wraps.
  localparam int CNT_W = (BUF_ADDR_W > 15) ? BUF_ADDR_W + 1 : 16;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(2 * IFG_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_FCS, S_IFG
  } state_t;

  state_t                r_state, w_state_next;
  logic                  r_nib, w_nib_next;
  logic [CNT_W-1:0]      r_cnt, w_cnt_next;
  logic [BUF_ADDR_W-1:0] r_len, w_len_next;
  logic                  r_corrupt, w_corrupt_next;
  logic [31:0]           r_crc, w_crc_next;
  logic [31:0]           r_fcs, w_fcs_next;
  logic [7:0]            r_byte, w_byte_next;
  logic                  r_busy, w_busy_next;
  logic                  r_done, w_done_next;
  logic                  r_rd, w_rd_next;
  logic [BUF_ADDR_W-1:0] r_addr, w_addr_next;
  logic                  r_dv, w_dv_next;
  logic [3:0]            r_data, w_data_next;

  logic [CNT_W-1:0]      w_len_ext;
  logic [CNT_W-1:0]      w_len_last;
  logic                  w_len_nz;
  logic [31:0]           w_fcs_init;

  // Reflected CRC-32 over one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign w_len_ext  = CNT_W'(r_len);
  assign w_len_last = w_len_ext - CNT_W'(1);
  assign w_len_nz   = (r_len != '0);
  // FCS is the complemented CRC; the corrupt option flips bit 0 of byte 0.
  assign w_fcs_init = ~r_crc ^ {31'h0, r_corrupt};

  // Next-slot decode: r_state/r_nib/r_cnt describe the nibble on the wire now;
  // this block picks the following nibble and the registered outputs for it.
  always_comb begin
    w_state_next   = r_state;
    w_nib_next     = r_nib;
    w_cnt_next     = r_cnt;
    w_len_next     = r_len;
    w_corrupt_next = r_corrupt;
    w_crc_next     = r_crc;
    w_fcs_next     = r_fcs;
    w_byte_next    = r_byte;
    w_addr_next    = r_addr;
    w_rd_next      = 1'b0;
    w_dv_next      = 1'b0;
    w_data_next    = 4'h0;
    w_busy_next    = 1'b1;
    w_done_next    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy_next = 1'b0;
        if (send_i) begin
          w_state_next   = S_PREAMBLE;
          w_nib_next     = 1'b0;
          w_cnt_next     = '0;
          w_len_next     = frame_len_i;
          w_corrupt_next = crc_corrupt_i;
          w_crc_next     = 32'hFFFFFFFF;
          w_busy_next    = 1'b1;
          w_dv_next      = 1'b1;
          w_data_next    = 4'h5;
        end
      end
      S_PREAMBLE: begin
        w_dv_next   = 1'b1;
        w_data_next = 4'h5;
        w_nib_next  = ~r_nib;
        if (r_nib) begin
          if (r_cnt == PRE_LAST) begin
            w_state_next = S_SFD;
            // Byte 0 is requested during the SFD low nibble.
            if (w_len_nz) begin
              w_rd_next   = 1'b1;
              w_addr_next = '0;
            end
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end
      S_SFD: begin
        w_dv_next  = 1'b1;
        w_nib_next = ~r_nib;
        if (!r_nib) begin
          w_data_next = 4'hD;
        end else begin
          w_cnt_next = '0;
          if (w_len_nz) begin
            w_state_next = S_DATA;
            w_data_next  = buf_data_i[3:0];
            w_byte_next  = buf_data_i;
            if (w_len_ext > CNT_W'(1)) begin
              w_rd_next   = 1'b1;
              w_addr_next = BUF_ADDR_W'(1);
            end
          end else begin
            w_state_next = S_FCS;
            w_data_next  = w_fcs_init[3:0];
            w_fcs_next   = w_fcs_init >> 4;
          end
        end
      end
      S_DATA: begin
        w_dv_next  = 1'b1;
        w_nib_next = ~r_nib;
        if (!r_nib) begin
          w_data_next = r_byte[7:4];
          w_crc_next  = crc_byte(r_crc, r_byte);
        end else if (r_cnt == w_len_last) begin
          w_state_next = S_FCS;
          w_cnt_next   = '0;
          w_data_next  = w_fcs_init[3:0];
          w_fcs_next   = w_fcs_init >> 4;
        end else begin
          w_cnt_next  = r_cnt + CNT_W'(1);
          w_data_next = buf_data_i[3:0];
          w_byte_next = buf_data_i;
          // Prefetch two ahead, never past the last payload byte.
          if ((r_cnt + CNT_W'(2)) < w_len_ext) begin
            w_rd_next   = 1'b1;
            w_addr_next = BUF_ADDR_W'(r_cnt + CNT_W'(2));
          end
        end
      end
      S_FCS: begin
        if (r_cnt == FCS_LAST) begin
          w_state_next = S_IFG;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next  = r_cnt + CNT_W'(1);
          w_dv_next   = 1'b1;
          w_data_next = r_fcs[3:0];
          w_fcs_next  = r_fcs >> 4;
        end
      end
      S_IFG: begin
        if (r_cnt == IFG_LAST) begin
          w_state_next = S_IDLE;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops every output immediately.
  always_ff @(posedge rx_clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state   <= S_IDLE;
      r_nib     <= 1'b0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_corrupt <= 1'b0;
      r_crc     <= 32'hFFFFFFFF;
      r_fcs     <= '0;
      r_byte    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd      <= 1'b0;
      r_addr    <= '0;
      r_dv      <= 1'b0;
      r_data    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_nib     <= w_nib_next;
      r_cnt     <= w_cnt_next;
      r_len     <= w_len_next;
      r_corrupt <= w_corrupt_next;
      r_crc     <= w_crc_next;
      r_fcs     <= w_fcs_next;
      r_byte    <= w_byte_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_rd      <= w_rd_next;
      r_addr    <= w_addr_next;
      r_dv      <= w_dv_next;
      r_data    <= w_data_next;
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign buf_rd_o   = r_rd;
  assign buf_addr_o = r_addr;
  assign rx_dv_o    = r_dv;
  assign rx_data_o  = r_data;

endmodule

// File: tb/tb_iob_eth_mii_rx_driver.sv
// Directed bench for iob_eth_mii_rx_driver: captures each frame from the MII
// side and checks framing, payload, FCS, timing and the read stream.
module tb_iob_eth_mii_rx_driver;
  localparam int AW  = 11;
  localparam int PRE = 7;
  localparam int IFG = 12;

  logic          rx_clk_i = 1'b0;
  logic          arst_i = 1'b0;
  logic          send_i = 1'b0;
  logic [AW-1:0] frame_len_i = '0;
  logic          crc_corrupt_i = 1'b0;
  logic          busy_o, done_o, buf_rd_o, rx_dv_o;
  logic [AW-1:0] buf_addr_o;
  logic [7:0]    buf_data_i = 8'h00;
  logic [3:0]    rx_data_o;

  iob_eth_mii_rx_driver #(
    .BUF_ADDR_W(AW), .PREAMBLE_LEN(PRE), .IFG_BYTES(IFG)
  ) dut (
    .rx_clk_i(rx_clk_i), .arst_i(arst_i), .send_i(send_i),
    .frame_len_i(frame_len_i), .crc_corrupt_i(crc_corrupt_i),
    .busy_o(busy_o), .done_o(done_o), .buf_rd_o(buf_rd_o),
    .buf_addr_o(buf_addr_o), .buf_data_i(buf_data_i),
    .rx_dv_o(rx_dv_o), .rx_data_o(rx_data_o)
  );

  always #5 rx_clk_i = ~rx_clk_i;

  // Frame buffer: data is valid only in the cycle after a read strobe.
  logic [7:0] mem [0:2047];
  always @(posedge rx_clk_i) buf_data_i <= buf_rd_o ? mem[buf_addr_o] : 8'hEE;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_q[$];
  int   dv_cnt, done_cyc, rd_cnt, rd_bad, dv_rehigh;
  logic c1_dv, c1_busy;
  logic [3:0] c1_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input int n, input logic cor);
    frame_len_i   = AW'(n);
    crc_corrupt_i = cor;
    @(negedge rx_clk_i); send_i = 1'b1;   // cycle 0
    @(negedge rx_clk_i); send_i = 1'b0;   // now inside cycle 1
  endtask

  // Sample once per cycle from cycle 1 until done_o or the cycle budget.
  task automatic collect(input int max_cyc, input int pulse_at);
    int cyc;
    int nibs;
    logic [3:0] lo;
    logic seen_low;
    rx_q.delete();
    dv_cnt = 0; done_cyc = -1; rd_cnt = 0; rd_bad = 0; dv_rehigh = 0;
    nibs = 0; lo = 4'h0; seen_low = 1'b0;
    cyc = 1;
    while (cyc <= max_cyc) begin
      if (cyc == 1) begin
        c1_dv = rx_dv_o; c1_busy = busy_o; c1_data = rx_data_o;
      end
      if (rx_dv_o) begin
        if (seen_low) dv_rehigh++;
        dv_cnt++;
        if (nibs % 2 == 0) lo = rx_data_o;
        else rx_q.push_back({rx_data_o, lo});
        nibs++;
      end else if (dv_cnt > 0) begin
        seen_low = 1'b1;
      end
      if (buf_rd_o) begin
        if (buf_addr_o !== AW'(rd_cnt)) rd_bad++;
        rd_cnt++;
      end
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
      send_i = (cyc == pulse_at);
      @(negedge rx_clk_i);
      cyc++;
    end
    send_i = 1'b0;
  endtask

  function automatic logic [31:0] fcs_word();
    int sz = rx_q.size();
    if (sz < 4) return 32'hDEADDEAD;
    return {rx_q[sz-1], rx_q[sz-2], rx_q[sz-3], rx_q[sz-4]};
  endfunction

  // Running CRC register over payload plus FCS; a good frame leaves the
  // well-known CRC-32 residue 0xDEBB20E3.
  function automatic logic [31:0] residue();
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = PRE + 1; i < rx_q.size(); i++) begin
      c ^= {24'h0, rx_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic check_frame(input string tag, input int n);
    int sz = rx_q.size();
    int hdr_bad = 0;
    int pay_bad = 0;
    if (sz >= PRE + 1) begin
      for (int i = 0; i < PRE; i++) if (rx_q[i] !== 8'h55) hdr_bad++;
      if (rx_q[PRE] !== 8'hD5) hdr_bad++;
    end else begin
      hdr_bad = 1;
    end
    for (int i = 0; i < n; i++) begin
      if (PRE + 1 + i < sz) begin
        if (rx_q[PRE+1+i] !== mem[i]) pay_bad++;
      end else begin
        pay_bad++;
      end
    end
    check({tag, "_c1_dv"},     32'(c1_dv), 32'd1);
    check({tag, "_c1_busy"},   32'(c1_busy), 32'd1);
    check({tag, "_c1_data"},   32'(c1_data), 32'h5);
    check({tag, "_bytes"},     32'(sz), 32'(PRE + 1 + n + 4));
    check({tag, "_hdr_bad"},   32'(hdr_bad), 32'd0);
    check({tag, "_pay_bad"},   32'(pay_bad), 32'd0);
    check({tag, "_dv_cyc"},    32'(dv_cnt), 32'(24 + 2 * n));
    check({tag, "_dv_rehigh"}, 32'(dv_rehigh), 32'd0);
    check({tag, "_done_cyc"},  32'(done_cyc), 32'(49 + 2 * n));
    check({tag, "_rd_cnt"},    32'(rd_cnt), 32'(n));
    check({tag, "_rd_order"},  32'(rd_bad), 32'd0);
  endtask

  initial begin
    int rises, gap1, seen_done, prev, dv_hi;

    // Reset state
    #2 arst_i = 1'b1;
    repeat (3) @(negedge rx_clk_i);
    check("rst_dv",   32'(rx_dv_o), 32'd0);
    check("rst_data", 32'(rx_data_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_rd",   32'(buf_rd_o), 32'd0);
    check("rst_addr", 32'(buf_addr_o), 32'd0);
    arst_i = 1'b0;
    repeat (2) @(negedge rx_clk_i);
    check("idle_dv",   32'(rx_dv_o), 32'd0);
    check("idle_busy", 32'(busy_o), 32'd0);

    // "123456789": FCS bytes 26 39 F4 CB, dv for 42 cycles, done at 67
    for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
    start_frame(9, 1'b0);
    collect(200, -1);
    $display("txn: n=9 bytes=%0d dv=%0d done=%0d fcs=%08h", rx_q.size(), dv_cnt, done_cyc, fcs_word());
    check_frame("n9", 9);
    check("n9_fcs",  fcs_word(), 32'hCBF43926);
    check("n9_dv42", 32'(dv_cnt), 32'd42);
    check("n9_d67",  32'(done_cyc), 32'd67);

    // Same payload with corruption: bit 0 of the first FCS byte flips
    start_frame(9, 1'b1);
    collect(200, -1);
    $display("txn: n=9 corrupt fcs=%08h", fcs_word());
    check_frame("n9c", 9);
    check("n9c_fcs", fcs_word(), 32'hCBF43927);

    // Empty payload: FCS of nothing is 0, no buffer reads
    start_frame(0, 1'b0);
    collect(200, -1);
    $display("txn: n=0 bytes=%0d dv=%0d done=%0d fcs=%08h", rx_q.size(), dv_cnt, done_cyc, fcs_word());
    check_frame("n0", 0);
    check("n0_fcs", fcs_word(), 32'h00000000);

    // 64-byte random payload, good and corrupted
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    start_frame(64, 1'b0);
    collect(400, -1);
    $display("txn: n=64 residue=%08h", residue());
    check_frame("n64", 64);
    check("n64_residue", residue(), 32'hDEBB20E3);
    start_frame(64, 1'b1);
    collect(400, -1);
    $display("txn: n=64 corrupt residue=%08h", residue());
    check_frame("n64c", 64);
    check("n64c_bad_residue", 32'(residue() != 32'hDEBB20E3), 32'd1);

    // Requests and length changes while busy are ignored
    start_frame(0, 1'b0);
    frame_len_i = AW'(5);
    collect(200, 10);
    $display("txn: drop test bytes=%0d done=%0d", rx_q.size(), done_cyc);
    check_frame("drop", 0);
    dv_hi = 0;
    repeat (5) begin
      @(negedge rx_clk_i);
      if (rx_dv_o || busy_o) dv_hi++;
    end
    check("drop_no_requeue", 32'(dv_hi), 32'd0);

    // send_i held high: the gap between frames is the IFG plus the IDLE
    // cycle in which the next request is taken
    frame_len_i = '0;
    @(negedge rx_clk_i); send_i = 1'b1;
    rises = 0; gap1 = 0; prev = 0;
    for (int c = 1; c <= 120; c++) begin
      @(negedge rx_clk_i);
      if (rx_dv_o && prev == 0) rises++;
      if (!rx_dv_o && rises == 1) gap1++;
      prev = int'(rx_dv_o);
    end
    send_i = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 100 && seen_done == 0; c++) begin
      @(negedge rx_clk_i);
      if (done_o) seen_done = 1;
    end
    $display("txn: back-to-back rises=%0d gap=%0d", rises, gap1);
    check("b2b_frames", 32'(rises), 32'd3);
    check("b2b_gap",    32'(gap1), 32'(2 * IFG + 1));
    check("b2b_drain",  32'(seen_done), 32'd1);

    // Reset in the middle of a 100-byte frame
    for (int i = 0; i < 100; i++) mem[i] = 8'($urandom);
    start_frame(100, 1'b0);
    repeat (29) @(negedge rx_clk_i);      // cycle 30
    check("mid_dv_before", 32'(rx_dv_o), 32'd1);
    arst_i = 1'b1;
    #1;
    $display("txn: reset mid-frame dv=%0b busy=%0b", rx_dv_o, busy_o);
    check("mid_dv",   32'(rx_dv_o), 32'd0);
    check("mid_data", 32'(rx_data_o), 32'd0);
    check("mid_busy", 32'(busy_o), 32'd0);
    check("mid_rd",   32'(buf_rd_o), 32'd0);
    @(negedge rx_clk_i); arst_i = 1'b0;
    repeat (3) @(negedge rx_clk_i);
    check("post_rst_dv",   32'(rx_dv_o), 32'd0);
    check("post_rst_busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
    start_frame(9, 1'b0);
    collect(200, -1);
    $display("txn: post-reset n=9 fcs=%08h", fcs_word());
    check_frame("post", 9);
    check("post_fcs", fcs_word(), 32'hCBF43926);

    // Maximum length: addresses 0..2046 in order, good FCS
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    start_frame(2047, 1'b0);
    collect(5000, -1);
    $display("txn: n=2047 reads=%0d residue=%08h done=%0d", rd_cnt, residue(), done_cyc);
    check_frame("max", 2047);
    check("max_residue", residue(), 32'hDEBB20E3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
